// File: rtl/ter_pkg.sv
// Ternary (mod-3) coefficient types and arithmetic helpers shared by the lane ALU.
// Codes: 00 = 0, 01 = +1, 11 = -1; 10 is illegal and reads as 0.
package ter_pkg;

    typedef logic [1:0] ter_t;

    localparam ter_t TER_ZERO = 2'b00;
    localparam ter_t TER_POS  = 2'b01;
    localparam ter_t TER_NEG  = 2'b11;
    localparam ter_t TER_BAD  = 2'b10;

    typedef enum logic [1:0] {
        TER_ADD    = 2'b00,
        TER_SUB    = 2'b01,
        TER_MUL    = 2'b10,
        TER_NEGATE = 2'b11
    } ter_op_t;

    function automatic ter_t ter_clean(ter_t x);
        return (x == TER_BAD) ? TER_ZERO : x;
    endfunction

    function automatic ter_t ter_neg(ter_t x);
        ter_t cx;
        cx = ter_clean(x);
        if (cx == TER_POS) return TER_NEG;
        if (cx == TER_NEG) return TER_POS;
        return TER_ZERO;
    endfunction

    // 1+1 = -1 and -1-1 = +1 in mod-3
    function automatic ter_t ter_add(ter_t x, ter_t y);
        ter_t cx;
        ter_t cy;
        cx = ter_clean(x);
        cy = ter_clean(y);
        if (cx == TER_ZERO) return cy;
        if (cy == TER_ZERO) return cx;
        if (cx == cy) return ter_neg(cx);
        return TER_ZERO;
    endfunction

    function automatic ter_t ter_mul(ter_t x, ter_t y);
        ter_t cx;
        ter_t cy;
        cx = ter_clean(x);
        cy = ter_clean(y);
        if ((cx == TER_ZERO) || (cy == TER_ZERO)) return TER_ZERO;
        return (cx == cy) ? TER_POS : TER_NEG;
    endfunction

endpackage

// File: rtl/ter_vec_alu_if.sv
// Beat stream interface of the ternary vector ALU: input beats, result beats, error flag.
interface ter_vec_alu_if
    import ter_pkg::*;
#(
    parameter int unsigned LANES = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic [2*LANES-1:0]   in_a;
    logic [2*LANES-1:0]   in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*LANES-1:0]   out_z;
    logic                 out_last;
    ter_t                 out_sum;
    logic                 err_invalid;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_z, out_last, out_sum, err_invalid
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_z, out_last, out_sum, err_invalid
    );
endinterface

// File: rtl/ter_lane.sv
// One ternary lane: combinational add/sub/mul/negate plus illegal-code detection.
module ter_lane
    import ter_pkg::*;
(
    input  ter_t    a,
    input  ter_t    b,
    input  ter_op_t op,
    output ter_t    z,
    output logic    illegal
);

    always_comb begin
        z       = TER_ZERO;
        illegal = (a == TER_BAD) || ((op != TER_NEGATE) && (b == TER_BAD));
        case (op)
            TER_ADD:    z = ter_add(a, b);
            TER_SUB:    z = ter_add(a, ter_neg(b));
            TER_MUL:    z = ter_mul(a, b);
            TER_NEGATE: z = ter_neg(a);
            default:    z = TER_ZERO;
        endcase
    end

endmodule

// File: rtl/ter_vec_alu.sv
// Streaming lane-parallel mod-3 ALU with polynomial framing and an x=1 evaluation sum.
// Optional build macro TER_VEC_ALU_SUM_EN enables the running-sum accumulator (out_sum).
module ter_vec_alu
    import ter_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int unsigned POLY_LEN = 701
) (
    input  logic          clk,
    input  logic          rst,
    ter_vec_alu_if.slave  bus
);

    localparam int unsigned BEATS = (POLY_LEN + LANES - 1) / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned W     = 2 * LANES;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, is_last, out_free;
    ter_t             lane_z [LANES];
    logic [LANES-1:0] lane_ill;
    logic [W-1:0]     beat_z;
    ter_t             sum_new;

    logic             in_ready_q, in_ready_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_z_q, out_z_d;
    logic             out_last_q, out_last_d;
    ter_t             out_sum_q, out_sum_d;
    logic             skid_valid_q, skid_valid_d;
    logic [W-1:0]     skid_z_q, skid_z_d;
    logic             skid_last_q, skid_last_d;
    ter_t             skid_sum_q, skid_sum_d;

    assign is_last  = (cnt_q == CNT_W'(BEATS - 1));
    assign accept   = bus.in_valid & in_ready_q;
    assign out_free = ~out_valid_q | bus.out_ready;

    // Lanes past POLY_LEN on the final beat are padding and read as zero
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int unsigned IDX = (BEATS - 1) * LANES + i;
        localparam bit          PAD = (IDX >= POLY_LEN);

        ter_lane u_lane (
            .a       (bus.in_a[2*i +: 2]),
            .b       (bus.in_b[2*i +: 2]),
            .op      (ter_op_t'(bus.in_op)),
            .z       (lane_z[i]),
            .illegal (lane_ill[i])
        );

        assign beat_z[2*i +: 2] = (PAD && is_last) ? TER_ZERO : lane_z[i];
    end

`ifdef TER_VEC_ALU_SUM_EN
    ter_t acc_q;
    ter_t beat_sum;

    always_comb begin
        beat_sum = TER_ZERO;
        for (int unsigned j = 0; j < LANES; j++) begin
            beat_sum = ter_add(beat_sum, beat_z[2*j +: 2]);
        end
    end

    assign sum_new = ter_add(acc_q, beat_sum);

    // Accumulates on acceptance; clears on the last beat of each polynomial
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= TER_ZERO;
        end else if (accept) begin
            acc_q <= is_last ? TER_ZERO : sum_new;
        end
    end
`else
    assign sum_new = TER_ZERO;
`endif

    // Output register plus one skid entry; in_ready tracks skid-empty one cycle late
    always_comb begin
        cnt_d        = cnt_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        out_z_d      = out_z_q;
        out_last_d   = out_last_q;
        out_sum_d    = out_sum_q;
        skid_valid_d = skid_valid_q;
        skid_z_d     = skid_z_q;
        skid_last_d  = skid_last_q;
        skid_sum_d   = skid_sum_q;

        if (accept) begin
            cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
            err_d = err_q | (|lane_ill);
        end

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_z_d      = skid_z_q;
                out_last_d   = skid_last_q;
                out_sum_d    = skid_sum_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_z_d     = beat_z;
                out_last_d  = is_last;
                out_sum_d   = sum_new;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_z_d     = beat_z;
            skid_last_d  = is_last;
            skid_sum_d   = sum_new;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_z_q      <= '0;
            out_last_q   <= 1'b0;
            out_sum_q    <= TER_ZERO;
            skid_valid_q <= 1'b0;
            skid_z_q     <= '0;
            skid_last_q  <= 1'b0;
            skid_sum_q   <= TER_ZERO;
        end else begin
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_z_q      <= out_z_d;
            out_last_q   <= out_last_d;
            out_sum_q    <= out_sum_d;
            skid_valid_q <= skid_valid_d;
            skid_z_q     <= skid_z_d;
            skid_last_q  <= skid_last_d;
            skid_sum_q   <= skid_sum_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_z       = out_z_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_sum     = out_sum_q;
    assign bus.err_invalid = err_q;

endmodule

// File: tb/tb_ter_vec_alu.sv
// Scoreboard bench for ter_vec_alu (LANES=4, POLY_LEN=10); honours TER_VEC_ALU_SUM_EN
// to decide whether out_sum is expected to carry the polynomial sum or stay 00.
module tb_ter_vec_alu;
    import ter_pkg::*;

    localparam int L     = 4;
    localparam int PL    = 10;
    localparam int BEATS = (PL + L - 1) / L;
    localparam int W     = 2 * L;
`ifdef TER_VEC_ALU_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] z;
        logic         last;
        logic [1:0]   sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ter_vec_alu_if #(.LANES(L)) bus ();

    ter_vec_alu #(.LANES(L), .POLY_LEN(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_beat = 0;
    int   m_sum  = 0;
    bit   stim_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int dec(logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] enc(int v);
        case (v)
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rand_ter();
        return enc(int'($urandom_range(0, 2)));
    endfunction

    // Reference: coefficient values as integers mod 3, framed by global coefficient index
    task automatic model_push(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   va, vb, r;
        e.last = (m_beat == BEATS - 1);
        e.z    = '0;
        for (int i = 0; i < L; i++) begin
            va = dec(a[2*i +: 2]);
            vb = dec(b[2*i +: 2]);
            case (op)
                2'd0:    r = (va + vb) % 3;
                2'd1:    r = (va + 3 - vb) % 3;
                2'd2:    r = (va * vb) % 3;
                default: r = (3 - va) % 3;
            endcase
            if (m_beat * L + i >= PL) r = 0;
            e.z[2*i +: 2] = enc(r);
            m_sum = (m_sum + r) % 3;
        end
        e.sum = (SUM_EN && e.last) ? enc(m_sum) : 2'b00;
        if (e.last) begin
            m_sum  = 0;
            m_beat = 0;
        end else begin
            m_beat++;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: in_ready=0 for %0d cycles, expected 1", waited);
                break;
            end
        end
        model_push(op, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_beat(output logic [W-1:0] a, output logic [W-1:0] b);
        for (int i = 0; i < L; i++) begin
            a[2*i +: 2] = rand_ter();
            b[2*i +: 2] = rand_ter();
        end
    endtask

    task automatic backpressure();
        int held   = 0;
        bit ir_low = 1'b0;
        fork
            begin
                logic [W-1:0] a, b;
                for (int k = 0; k < 6; k++) begin
                    rand_beat(a, b);
                    send_beat(2'(k % 4), a, b);
                end
                idle();
            end
            begin
                int n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!bus.out_valid && n < 50);
                chk("bp_first_output_seen", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b0;
                held = 1;
                repeat (3) begin
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) held++;
                    ir_low = !bus.in_ready;
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        chk("bp_beats_held", 32'(held), 32'd2);
        chk("bp_in_ready_low", 32'(ir_low), 32'd1);
    endtask

    // Monitor: compares the head of the scoreboard whenever a beat is presented
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got z=%0h with no expected beat", bus.out_z);
            end else begin
                mon_e = exp_q[0];
                chk("out_z", 32'(bus.out_z), 32'(mon_e.z));
                chk("out_last", 32'(bus.out_last), 32'(mon_e.last));
                if (!SUM_EN || mon_e.last) chk("out_sum", 32'(bus.out_sum), 32'(mon_e.sum));
                if (bus.out_ready) mon_e = exp_q.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        stim_done     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_z", 32'(bus.out_z), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_err_invalid", 32'(bus.err_invalid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // All-ones add: every coefficient -1, sum of 10 coefficients = -1
        for (int k = 0; k < 3; k++) send_beat(2'b00, 8'h55, 8'h55);
        idle();
        drain();

        // Every legal (a,b) pair on every lane for each op
        for (int op = 0; op < 4; op++) begin
            for (int p = 0; p < 9; p++) begin
                for (int i = 0; i < L; i++) begin
                    a[2*i +: 2] = enc(((p + i) % 9) / 3);
                    b[2*i +: 2] = enc(((p + i) % 9) % 3);
                end
                send_beat(2'(op), a, b);
            end
        end
        idle();
        drain();

        backpressure();
        drain();

        // Random ops, random gaps, random downstream stalls
        fork
            begin
                for (int k = 0; k < 45; k++) begin
                    rand_beat(a, b);
                    send_beat(2'($urandom_range(0, 3)), a, b);
                    if ($urandom_range(0, 4) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Illegal code in lane 0 reads as zero and latches the error flag
        chk("err_before_illegal", 32'(bus.err_invalid), 32'd0);
        send_beat(2'b00, 8'b01_01_01_10, 8'h55);
        idle();
        chk("err_after_illegal", 32'(bus.err_invalid), 32'd1);
        send_beat(2'b10, 8'h55, 8'hFF);
        send_beat(2'b01, 8'h00, 8'h55);
        idle();
        drain();
        chk("err_sticky", 32'(bus.err_invalid), 32'd1);

        // Asynchronous reset in the middle of a polynomial
        send_beat(2'b00, 8'h55, 8'h55);
        send_beat(2'b00, 8'h55, 8'h55);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_out_z", 32'(bus.out_z), 32'd0);
        chk("async_rst_out_last", 32'(bus.out_last), 32'd0);
        chk("async_rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("async_rst_err", 32'(bus.err_invalid), 32'd0);
        exp_q.delete();
        m_beat = 0;
        m_sum  = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_mid_rst", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 3; k++) send_beat(2'b00, 8'h55, 8'h55);
        idle();
        drain();
        chk("err_after_mid_rst", 32'(bus.err_invalid), 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ter_vec_alu.md
Name: ter_vec_alu

Overview:
- Streaming, lane-parallel ternary (mod-3) arithmetic unit for polynomial coefficients in the NTRU-HRSS datapath.
- Each beat carries LANES coefficient pairs and applies add, sub, mul or negate per lane.
- Frames beats into polynomials of POLY_LEN coefficients and accumulates the result polynomial's evaluation at x=1 (sum mod 3), used for Phi1-divisibility checks.
- Sits between coefficient memories and the lift/inverse stages, with valid/ready on both sides.

Parameters:
- LANES, 8, coefficients processed per beat.
- POLY_LEN, 701, coefficients per polynomial; BEATS = ceil(POLY_LEN/LANES).
- CNT_W, $clog2(BEATS), beat-counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_op  in  2  00 add a+b, 01 sub a-b, 10 mul a*b, 11 neg -a (b ignored).
- in_a  in  2*LANES  lane i at [2i+1:2i], ternary.
- in_b  in  2*LANES  lane i at [2i+1:2i], ternary.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_z  out  2*LANES  result lanes.
- out_last  out  1  beat is last of polynomial.
- out_sum  out  2  mod-3 sum of all result coefficients of the polynomial; meaningful only when out_last=1.
- err_invalid  out  1  sticky: an illegal code was seen on an input.

Behaviour:
- Ternary encoding: 00=0, 01=+1, 11=-1. Code 10 is illegal; it is treated as 0 and sets err_invalid, which stays set until rst.
- Reset (async assert, sync release to clk):
  - out_valid=0, out_z=0, out_last=0, out_sum=00, err_invalid=0.
  - Beat counter=0, accumulator=00, skid buffer empty.
  - in_ready=1 from the first clock after reset release.
- Reset mid-polynomial discards all in-flight beats and the partial sum. The next accepted beat is beat 0.
- Datapath:
  - Per-lane combinational op, then one output register. Latency: accept at edge k gives out_valid at edge k (registered), visible in cycle k+1.
  - in_op is sampled per beat; ops may change within a polynomial.
- Framing:
  - Beat counter increments on each accepted beat and wraps from BEATS-1 to 0.
  - out_last=1 on the beat with counter=BEATS-1.
  - On that beat, lanes with global index >= POLY_LEN are forced to 00 on out_z and excluded from the sum.
- Accumulator:
  - sum_next = acc + sum of the beat's result lanes, mod 3.
  - On a last beat, out_sum carries the final value including that beat, and acc clears to 00 in the same edge.
  - Otherwise out_sum shows the running acc.
- Handshake:
  - One output register plus one skid register. in_ready is registered and equals "skid empty"; it never depends combinationally on out_ready.
  - Full throughput of 1 beat/clk while out_ready=1.
  - out_ready=0 with out_valid=1: out_z, out_last and out_sum are held stable. One more beat may be absorbed into skid, then in_ready drops.
  - out_ready rising drains skid next; in_ready returns 1 the following cycle.
  - Simultaneous accept and drain with skid empty: data passes straight to the output register, skid stays empty.
- The accumulator and counter update at input acceptance, not output. Skid entries therefore store their own last flag and sum.

Optional Feature:
- Macro TER_VEC_ALU_SUM_EN.
- Defined: accumulator present, out_sum as above.
- Undefined: no accumulator logic, out_sum tied to 00. Framing and out_last are unchanged.

Decomposition:
- Package ter_pkg:
  - typedef ter_t (logic [1:0]).
  - Constants TER_ZERO=2'b00, TER_POS=2'b01, TER_NEG=2'b11.
  - enum ter_op_t {TER_ADD, TER_SUB, TER_MUL, TER_NEG}.
  - Function ter_add for accumulator reduction.
- Sub-module ter_lane: combinational, one lane. Inputs a, b, op; outputs z and illegal flag. Instantiated LANES times via generate.

Test Plan:
- LANES=4, POLY_LEN=10, op=add, a lanes all 01, b lanes all 01, 3 beats, out_ready=1:
  - out_z lanes = 11 for all lanes in beats 0-1.
  - Beat 2: lanes 0-1 = 11, lanes 2-3 = 00, out_last=1.
  - out_sum = (-1)*10 mod 3 = 11 (-1).
- mul/sub/neg exhaustive: all 9 legal (a,b) pairs on each lane.
  - mul: 01*11 = 11, 11*11 = 01.
  - sub: 00-01 = 11.
  - neg: -11 = 01.
- Backpressure: stream 6 beats, out_ready low 3 cycles after the first output.
  - in_ready falls after exactly 2 beats are held (output + skid).
  - No loss or duplication; order preserved; out_last lands on beats 2 and 5.
- Illegal code: in_a lane0 = 10, op=add, b=01.
  - out_z lane0 = 01, err_invalid=1 next cycle and stays 1 across later legal beats until rst.
- Reset mid-polynomial: assert rst asynchronously after beat 1 of 3.
  - Outputs clear immediately, without waiting for a clk edge.
  - After release, a new 3-beat polynomial gives out_last on its own third beat with a sum unaffected by the old beats.
- Build without TER_VEC_ALU_SUM_EN: rerun the first scenario.
  - Identical out_z and out_last; out_sum=00 throughout.
